// File: rtl/snax_acc_pkg.sv
// Purpose: shared types and constants for the snax_acc_responder slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: opcode enum, FSM state enum, latched-request metadata struct,
// opcode field position, and a legality helper.
package snax_acc_pkg;

  localparam int unsigned OpcodeLsb   = 12;
  localparam int unsigned OpcodeWidth = 3;
  // Wide enough for MulLatency up to 15.
  localparam int unsigned CntWidth    = 4;
  localparam int unsigned IdWidth     = 5;

  typedef enum logic [OpcodeWidth-1:0] {
    OP_MAC = 3'd0,
    OP_CLR = 3'd1,
    OP_RD  = 3'd2,
    OP_MUL = 3'd3
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Fields of an accepted request that must survive until the response.
  typedef struct packed {
    logic [IdWidth-1:0]     id;
    logic [OpcodeWidth-1:0] op;
  } req_meta_t;

  function automatic logic op_is_legal(input logic [OpcodeWidth-1:0] op);
    return op inside {OP_MAC, OP_CLR, OP_RD, OP_MUL};
  endfunction

endpackage

// File: rtl/snax_acc_mul_pipe.sv
// Purpose: unsigned DataWidth x DataWidth multiplier, low DataWidth bits kept.
// Latency: MulLatency cycles from i_in_vld to o_out_vld.
// Backpressure: none; free-running shift register, caller guarantees capacity.
//
// Ports: clk_i/rst_ni clock and async active-low reset; i_in_vld, i_a, i_b
// operand strobe and operands; o_out_vld, o_prod result strobe and product.
module snax_acc_mul_pipe #(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned MulLatency = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 i_in_vld,
  input  logic [DataWidth-1:0] i_a,
  input  logic [DataWidth-1:0] i_b,
  output logic                 o_out_vld,
  output logic [DataWidth-1:0] o_prod
);

  logic [DataWidth-1:0] w_prod;
  logic [DataWidth-1:0] r_prod [MulLatency];
  logic                 r_vld  [MulLatency];

  // The multiply sits ahead of the register chain; synthesis is expected to
  // retime it across the stages.
  assign w_prod = i_a * i_b;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MulLatency; i++) begin
        r_vld[i]  <= 1'b0;
        r_prod[i] <= '0;
      end
    end else begin
      r_vld[0] <= i_in_vld;
      if (i_in_vld) r_prod[0] <= w_prod;
      for (int i = 1; i < MulLatency; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_prod[i] <= r_prod[i-1];
      end
    end
  end

  assign o_out_vld = r_vld[MulLatency-1];
  assign o_prod    = r_prod[MulLatency-1];

endmodule

// File: rtl/snax_acc_responder.sv
// Purpose: accelerator-side offload responder doing unsigned MAC/CLR/RD/MUL.
// Latency: CLR/RD/error respond 1 cycle after accept; MUL/MAC MulLatency+1.
// Backpressure: single outstanding request; qready low until the response
//               handshakes, response held stable while pready is low.
//
// Ports: clk_i/rst_ni clock and async active-low reset; acc_q* request
// channel (addr, id, op word, two operands, valid/ready); acc_p* response
// channel (id, error, data, valid/ready).
module snax_acc_responder #(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned AccAddr    = 1,
  parameter int unsigned MulLatency = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [31:0]          acc_qaddr_i,
  input  logic [4:0]           acc_qid_i,
  input  logic [31:0]          acc_qdata_op_i,
  input  logic [DataWidth-1:0] acc_qdata_arga_i,
  input  logic [DataWidth-1:0] acc_qdata_argb_i,
  input  logic                 acc_qvalid_i,
  output logic                 acc_qready_o,
  output logic [4:0]           acc_pid_o,
  output logic                 acc_perror_o,
  output logic [DataWidth-1:0] acc_pdata_o,
  output logic                 acc_pvalid_o,
  input  logic                 acc_pready_i
);

  import snax_acc_pkg::*;

  state_e                 r_state, w_state_nxt;
  req_meta_t              r_meta;
  logic [CntWidth-1:0]    r_cnt;
  logic [DataWidth-1:0]   r_acc, r_pdata;
  logic                   r_perror;

  logic [OpcodeWidth-1:0] w_op;
  logic                   w_err, w_is_mul, w_accept, w_start_mul;
  logic                   w_mul_vld, w_qready, w_pvalid;
  logic [DataWidth-1:0]   w_prod, w_acc_sum;
  logic                   w_unused_op;

  assign w_op        = acc_qdata_op_i[OpcodeLsb +: OpcodeWidth];
  // Only the funct3 field selects the operation; the rest of the word is ignored.
  assign w_unused_op = ^{acc_qdata_op_i[31:OpcodeLsb+OpcodeWidth],
                         acc_qdata_op_i[OpcodeLsb-1:0]};
  assign w_err       = !op_is_legal(w_op) || (acc_qaddr_i != 32'(AccAddr));
  assign w_is_mul    = (w_op == OP_MAC) || (w_op == OP_MUL);
  assign w_accept    = acc_qvalid_i && (r_state == ST_IDLE);
  // Errored MUL/MAC requests never enter the multiplier.
  assign w_start_mul = w_accept && !w_err && w_is_mul;
  assign w_acc_sum   = r_acc + w_prod;

  snax_acc_mul_pipe #(
    .DataWidth  (DataWidth),
    .MulLatency (MulLatency)
  ) u_mul_pipe (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_in_vld  (w_start_mul),
    .i_a       (acc_qdata_arga_i),
    .i_b       (acc_qdata_argb_i),
    .o_out_vld (w_mul_vld),
    .o_prod    (w_prod)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_qready    = 1'b0;
    w_pvalid    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_qready = 1'b1;
        if (acc_qvalid_i) w_state_nxt = (!w_err && w_is_mul) ? ST_BUSY : ST_RESP;
      end
      ST_BUSY: begin
        if (w_mul_vld) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_pvalid = 1'b1;
        if (acc_pready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta   <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_pdata  <= '0;
      r_perror <= 1'b0;
    end else begin
      if (w_accept) begin
        r_meta   <= '{id: acc_qid_i, op: w_op};
        r_perror <= w_err;
        if (w_err) begin
          r_pdata <= '0;
        end else begin
          case (w_op)
            OP_MAC, OP_MUL: r_cnt <= CntWidth'(MulLatency - 1);
            OP_CLR: begin
              r_acc   <= '0;
              r_pdata <= '0;
            end
            OP_RD:   r_pdata <= r_acc;
            default: ;
          endcase
        end
      end
      if (r_state == ST_BUSY) begin
        if (r_cnt != '0) r_cnt <= r_cnt - CntWidth'(1);
        // Accumulator commits here, exactly once, regardless of later stalls.
        if (w_mul_vld) begin
          if (r_meta.op == OP_MAC) begin
            r_acc   <= w_acc_sum;
            r_pdata <= w_acc_sum;
          end else begin
            r_pdata <= w_prod;
          end
        end
      end
    end
  end

  assign acc_qready_o = w_qready;
  assign acc_pvalid_o = w_pvalid;
  assign acc_pid_o    = r_meta.id;
  assign acc_perror_o = r_perror;
  assign acc_pdata_o  = r_pdata;

  // The multiplier strobe and the latency counter must agree on when BUSY ends.
  a_cnt_matches_pipe: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state == ST_BUSY) |-> (w_mul_vld == (r_cnt == '0)));
  a_pipe_only_in_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_mul_vld |-> (r_state == ST_BUSY));

endmodule

// File: tb/tb_snax_acc_responder.sv
// Purpose: directed self-checking bench for snax_acc_responder.
// Latency: n/a.
// Backpressure: exercises response stalls and back-to-back requests.
module tb_snax_acc_responder;
  import snax_acc_pkg::*;

  localparam int unsigned ADDR = 1;
  localparam int          LAT  = 3;

  logic        clk_i            = 1'b0;
  logic        rst_ni           = 1'b1;
  logic [31:0] acc_qaddr_i      = '0;
  logic [4:0]  acc_qid_i        = '0;
  logic [31:0] acc_qdata_op_i   = '0;
  logic [63:0] acc_qdata_arga_i = '0;
  logic [63:0] acc_qdata_argb_i = '0;
  logic        acc_qvalid_i     = 1'b0;
  logic        acc_qready_o;
  logic [4:0]  acc_pid_o;
  logic        acc_perror_o;
  logic [63:0] acc_pdata_o;
  logic        acc_pvalid_o;
  logic        acc_pready_i     = 1'b1;

  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;

  snax_acc_responder #(
    .DataWidth  (64),
    .AccAddr    (ADDR),
    .MulLatency (LAT)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .acc_qaddr_i      (acc_qaddr_i),
    .acc_qid_i        (acc_qid_i),
    .acc_qdata_op_i   (acc_qdata_op_i),
    .acc_qdata_arga_i (acc_qdata_arga_i),
    .acc_qdata_argb_i (acc_qdata_argb_i),
    .acc_qvalid_i     (acc_qvalid_i),
    .acc_qready_o     (acc_qready_o),
    .acc_pid_o        (acc_pid_o),
    .acc_perror_o     (acc_perror_o),
    .acc_pdata_o      (acc_pdata_o),
    .acc_pvalid_o     (acc_pvalid_o),
    .acc_pready_i     (acc_pready_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0]  id;
    logic        err;
    logic [63:0] data;
    int          due;
  } rsp_t;

  rsp_t        m_q[$];
  logic [63:0] m_acc  = '0;
  bit          m_busy = 1'b0;
  bit          m_seen = 1'b0;

  // Works out the response a request must produce the moment it is accepted.
  task automatic model_accept();
    rsp_t        r;
    logic [2:0]  op;
    logic [63:0] p;
    bit          slow;
    op     = acc_qdata_op_i[14:12];
    p      = acc_qdata_arga_i * acc_qdata_argb_i;
    r.id   = acc_qid_i;
    r.err  = 1'b0;
    r.data = '0;
    slow   = 1'b0;
    if (acc_qaddr_i != ADDR || op > 3'd3) begin
      r.err = 1'b1;
    end else begin
      case (op)
        3'd0: begin m_acc = m_acc + p; r.data = m_acc; slow = 1'b1; end
        3'd1: m_acc = '0;
        3'd2: r.data = m_acc;
        default: begin r.data = p; slow = 1'b1; end
      endcase
    end
    r.due = cyc + 1 + (slow ? LAT : 0);
    m_q.push_back(r);
    m_busy = 1'b1;
  endtask

  // Compare process: checks every cycle against the model.
  initial forever begin
    @(negedge clk_i);
    if (!rst_ni) begin
      chk("reset_pvalid", acc_pvalid_o, 1'b0);
      chk("reset_qready", acc_qready_o, 1'b1);
      m_q.delete();
      m_acc  = '0;
      m_busy = 1'b0;
      m_seen = 1'b0;
    end else begin
      chk("qready", acc_qready_o, !m_busy);
      if (acc_pvalid_o) begin
        if (m_q.size() == 0) begin
          chk("spurious_pvalid", acc_pvalid_o, 1'b0);
        end else begin
          if (!m_seen) begin
            chk("rsp_latency", cyc, m_q[0].due);
            m_seen = 1'b1;
          end
          chk("pid", acc_pid_o, m_q[0].id);
          chk("perror", acc_perror_o, m_q[0].err);
          chk("pdata", acc_pdata_o, m_q[0].data);
          if (acc_pready_i) begin
            void'(m_q.pop_front());
            m_seen = 1'b0;
            m_busy = 1'b0;
          end
        end
      end else if (m_seen) begin
        chk("pvalid_drop", acc_pvalid_o, 1'b1);
      end
      if (acc_qvalid_i && acc_qready_o) model_accept();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle_q();
    acc_qvalid_i     = 1'b0;
    acc_qid_i        = 5'($urandom());
    acc_qaddr_i      = $urandom();
    acc_qdata_op_i   = $urandom();
    acc_qdata_arga_i = {$urandom(), $urandom()};
    acc_qdata_argb_i = {$urandom(), $urandom()};
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] id,
                      input logic [63:0] a, input logic [63:0] b, output int t_acc);
    logic [31:0] w;
    bit          got;
    w       = $urandom();
    w[14:12] = op;
    acc_qvalid_i     = 1'b1;
    acc_qaddr_i      = addr;
    acc_qid_i        = id;
    acc_qdata_op_i   = w;
    acc_qdata_arga_i = a;
    acc_qdata_argb_i = b;
    got   = 1'b0;
    t_acc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (acc_qready_o) begin
        got   = 1'b1;
        t_acc = cyc;
        break;
      end
    end
    chk("accept", got, 1'b1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_rsp(input string name, input logic [63:0] data, input logic err,
                          input logic [4:0] id, output int t_rsp);
    bit got;
    got   = 1'b0;
    t_rsp = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (acc_pvalid_o) begin
        got   = 1'b1;
        t_rsp = cyc;
        break;
      end
    end
    chk({name, "_seen"}, got, 1'b1);
    if (got) begin
      chk({name, "_pdata"}, acc_pdata_o, data);
      chk({name, "_perror"}, acc_perror_o, err);
      chk({name, "_pid"}, acc_pid_o, id);
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int ta, tp;
    int tb[4];

    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_qready", acc_qready_o, 1'b1);
    chk("rst_pvalid", acc_pvalid_o, 1'b0);
    chk("rst_pid", acc_pid_o, 5'd0);
    chk("rst_perror", acc_perror_o, 1'b0);
    chk("rst_pdata", acc_pdata_o, 64'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    idle_q();
    @(posedge clk_i);
    #1;

    // accumulate chain
    send(OP_CLR, ADDR, 5'd1, 64'd99, 64'd7, ta); idle_q();
    wait_rsp("clr", 64'd0, 1'b0, 5'd1, tp);
    chk("clr_latency", tp - ta, 1);
    send(OP_MAC, ADDR, 5'd2, 64'd3, 64'd5, ta); idle_q();
    wait_rsp("mac1", 64'd15, 1'b0, 5'd2, tp);
    chk("mac1_latency", tp - ta, 4);
    send(OP_MAC, ADDR, 5'd3, 64'd2, 64'd7, ta); idle_q();
    wait_rsp("mac2", 64'd29, 1'b0, 5'd3, tp);
    send(OP_RD, ADDR, 5'd4, 64'hDEAD, 64'hBEEF, ta); idle_q();
    wait_rsp("rd1", 64'd29, 1'b0, 5'd4, tp);
    chk("rd1_latency", tp - ta, 1);

    // multiply truncation and wrap
    send(OP_MUL, ADDR, 5'd5, 64'h1_0000_0000, 64'h1_0000_0000, ta); idle_q();
    wait_rsp("mul_trunc", 64'd0, 1'b0, 5'd5, tp);
    chk("mul_latency", tp - ta, 4);
    send(OP_MUL, ADDR, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, ta); idle_q();
    wait_rsp("mul_wrap", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 5'd6, tp);
    send(OP_RD, ADDR, 5'd7, 64'd0, 64'd0, ta); idle_q();
    wait_rsp("rd2", 64'd29, 1'b0, 5'd7, tp);

    // errors
    send(3'd7, ADDR, 5'h1A, 64'd5, 64'd5, ta); idle_q();
    wait_rsp("bad_op", 64'd0, 1'b1, 5'h1A, tp);
    chk("bad_op_latency", tp - ta, 1);
    send(OP_RD, ADDR + 1, 5'd8, 64'd0, 64'd0, ta); idle_q();
    wait_rsp("bad_addr", 64'd0, 1'b1, 5'd8, tp);
    send(OP_MAC, ADDR + 1, 5'd9, 64'd3, 64'd3, ta); idle_q();
    wait_rsp("bad_addr_mac", 64'd0, 1'b1, 5'd9, tp);
    chk("bad_addr_mac_latency", tp - ta, 1);
    send(OP_RD, ADDR, 5'd10, 64'd0, 64'd0, ta); idle_q();
    wait_rsp("rd3", 64'd29, 1'b0, 5'd10, tp);

    // response stall after MAC: 10 cycles with pready low
    acc_pready_i = 1'b0;
    send(OP_MAC, ADDR, 5'd11, 64'd1, 64'd1, ta); idle_q();
    wait_rsp("stall_mac", 64'd30, 1'b0, 5'd11, tp);
    repeat (9) begin
      @(negedge clk_i);
      chk("stall_pvalid", acc_pvalid_o, 1'b1);
      chk("stall_pdata", acc_pdata_o, 64'd30);
      chk("stall_pid", acc_pid_o, 5'd11);
      chk("stall_qready", acc_qready_o, 1'b0);
    end
    @(posedge clk_i);
    #1 acc_pready_i = 1'b1;
    @(posedge clk_i);
    #1;
    send(OP_RD, ADDR, 5'd12, 64'd0, 64'd0, ta); idle_q();
    wait_rsp("rd_after_stall", 64'd30, 1'b0, 5'd12, tp);

    // back-to-back reads with qvalid held high: accept, response, accept
    for (int i = 0; i < 4; i++) begin
      send(OP_RD, ADDR, 5'(16 + i), {$urandom(), $urandom()}, {$urandom(), $urandom()}, tb[i]);
    end
    idle_q();
    repeat (3) @(posedge clk_i);
    #1;
    for (int i = 1; i < 4; i++) chk("b2b_spacing", tb[i] - tb[i-1], 2);

    // reset while a MAC is in the multiplier
    send(OP_MAC, ADDR, 5'd20, 64'd4, 64'd4, ta); idle_q();
    @(posedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_busy_qready", acc_qready_o, 1'b1);
    chk("rst_busy_pvalid", acc_pvalid_o, 1'b0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    send(OP_RD, ADDR, 5'd21, 64'd0, 64'd0, ta); idle_q();
    wait_rsp("rd_after_rst", 64'd0, 1'b0, 5'd21, tp);

    // reset while a response is stalled: pvalid must drop at once
    acc_pready_i = 1'b0;
    send(OP_RD, ADDR, 5'd22, 64'd0, 64'd0, ta); idle_q();
    wait_rsp("rd_stalled", 64'd0, 1'b0, 5'd22, tp);
    rst_ni = 1'b0;
    #1;
    chk("rst_resp_pvalid", acc_pvalid_o, 1'b0);
    chk("rst_resp_qready", acc_qready_o, 1'b1);
    chk("rst_resp_pid", acc_pid_o, 5'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    acc_pready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    send(OP_RD, ADDR, 5'd23, 64'd0, 64'd0, ta); idle_q();
    wait_rsp("rd_final", 64'd0, 1'b0, 5'd23, tp);

    repeat (5) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    miscompares++;
    $display("FAIL watchdog: run did not complete, got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
